pcm_pwm_dac: RTL and testbench
==============================

Name: pcm_pwm_dac

Overview:
- Audio sink for the 8-bit PCM stream produced by the bytebeat generator.
- Consumes samples over a valid/ready handshake at a fixed sample rate set by a clock divider.
- Converts each sample into a 1-bit PWM waveform that drives an output pin, through an external RC low-pass, to a speaker.
- Counts underruns so the bench and firmware can tell whether the generator keeps up.

Parameters:
- WIDTH, 8, PCM sample width; the PWM period is 2**WIDTH clocks.
- PERIODS_PER_SAMPLE, 2, number of PWM periods per sample frame (1..255).
- CNT_WIDTH, 8, width of the saturating underrun counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  design enable; low freezes the block.
- pcm_in  input  WIDTH  sample data.
- pcm_vld  input  1  sample valid.
- pcm_rdy  output  1  block can accept a sample.
- pwm_out  output  1  modulated audio bit, registered.
- frame  output  1  one-cycle pulse at each sample-frame boundary.
- underrun  output  1  one-cycle pulse when a frame boundary finds no sample.
- underrun_cnt  output  CNT_WIDTH  saturating underrun count.

Behaviour:
- Reset (async assert, sync deassert):
  - active = MIDSCALE (0x80); hold register empty.
  - pwm_cnt = 0; period_cnt = 0.
  - pwm_out = 0, pcm_rdy = 0, frame = 0, underrun = 0, underrun_cnt = 0.
- pcm_rdy = en && !hold_full. It rises on the first clock after reset release if en is high.
- Accept: pcm_vld && pcm_rdy on a rising edge.
  - Not at a boundary: the sample goes to the hold register, hold_full = 1.
- pwm_cnt free-runs 0..2**WIDTH-1 and wraps.
  - period_cnt increments on each wrap and wraps at PERIODS_PER_SAMPLE-1.
- Boundary cycle: pwm_cnt == max && period_cnt == PERIODS_PER_SAMPLE-1. On that edge:
  - hold_full: active <= hold; hold_full <= 0. pcm_rdy returns next cycle.
  - Hold empty and a sample accepted in the same cycle: bypass, active <= pcm_in; hold stays empty; no underrun.
  - Neither: active is unchanged (previous sample repeats). underrun pulses for 1 cycle. underrun_cnt += 1, saturating at 2**CNT_WIDTH-1.
  - frame pulses for 1 cycle, registered, coincident with pwm_cnt returning to 0.
- pwm_out <= (pwm_cnt < active), registered, one-cycle latency.
  - Duty is active / 2**WIDTH: 0x00 gives constant low, 0xFF gives 255 high of 256.
  - A new active value takes effect from the first PWM period of the new frame.
- en low:
  - All counters and registers hold; pwm_out forced 0; pcm_rdy = 0.
  - frame and underrun are suppressed.
  - When en rises again, operation resumes from the frozen counts.
- Reset asserted mid-frame: immediate return to reset values; any held sample is discarded.

Optional Feature:
- Macro: PCM_PWM_DAC_SIGMA_DELTA_EN.
- Defined: the PWM comparator is replaced by a first-order sigma-delta modulator.
  - Accumulator is WIDTH+1 bits, reset to 0.
  - Each cycle: acc <= {1'b0, acc[WIDTH-1:0]} + active.
  - pwm_out <= carry bit acc[WIDTH] of the new sum.
  - Frame timing, handshake and underrun behaviour are unchanged.
  - Average density over any 256-cycle window equals active/256 ±1.
- Undefined: plain PWM as above; no accumulator is synthesised.

Decomposition:
- Package pcm_dac_pkg:
  - MIDSCALE constant (1 << (WIDTH-1)).
  - Default WIDTH and CNT_WIDTH.
  - Typedef for the sample word.
- Sub-module pcm_pwm_mod:
  - Modulator core only: inputs clk, rst_n, en, active value; output pwm_out.
  - Contains both the PWM and the sigma-delta variants under the macro.
- The top handles the handshake, hold register, frame counters and underrun logic.

Test Plan:
All scenarios use WIDTH=8 and PERIODS_PER_SAMPLE=2 (512-clock frame).
1. Reset release, en=1, no samples -> pcm_rdy=1 one cycle after release; pwm_out high 128 of every 256 cycles; first frame pulse at cycle 512, together with underrun=1 and underrun_cnt=1.
2. pcm_in=0x40 with pcm_vld held high from cycle 10 -> accepted at cycle 10 and pcm_rdy drops. At the boundary, active=0x40 and pcm_rdy rises the next cycle. Both following PWM periods show 64 high cycles.
3. Samples 0x00 then 0xFF in successive frames -> pwm_out stuck low for 512 cycles, then 255 high / 1 low per period; no underrun pulses.
4. No samples for 300 frames -> underrun pulses every 512 cycles; underrun_cnt saturates at 255; duty stays at the last sample.
5. Hold empty, pcm_vld asserted only on the boundary cycle with 0xC0 -> bypass load: duty becomes 192/256 from the next period; no underrun; hold stays empty.
6. en dropped at cycle 200 for 50 cycles -> pwm_out=0, pcm_rdy=0, counters frozen; frame boundary shifts to cycle 562. With the macro defined, rerun scenario 2 and check 64±1 ones per 256 cycles.

Source files
------------

// File: rtl/pcm_dac_pkg.sv
// Shared constants and types for the PCM-to-PWM audio DAC.
// Optional sigma-delta modulation is selected by PCM_PWM_DAC_SIGMA_DELTA_EN.
package pcm_dac_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_CNT_WIDTH = 8;
    localparam int DEFAULT_PERIODS   = 2;

    typedef logic [DEFAULT_WIDTH-1:0] sample_t;

    localparam sample_t MIDSCALE = sample_t'(1 << (DEFAULT_WIDTH - 1));

    // Source of the next active sample at a frame boundary
    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_HOLD,
        LOAD_BYPASS
    } load_e;

    function automatic int midscale(input int width);
        return 1 << (width - 1);
    endfunction

endpackage

// File: rtl/pcm_pwm_mod.sv
// Modulator core: turns the active sample into a registered 1-bit stream.
// PCM_PWM_DAC_SIGMA_DELTA_EN swaps the PWM comparator for a first-order sigma-delta.
module pcm_pwm_mod
    import pcm_dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] active,
`ifndef PCM_PWM_DAC_SIGMA_DELTA_EN
    input  logic [WIDTH-1:0] pwm_cnt,
`endif
    output logic             pwm_out
);

`ifdef PCM_PWM_DAC_SIGMA_DELTA_EN
    logic [WIDTH:0] acc;
    logic [WIDTH:0] sum;

    // Carry out of the residue-plus-sample sum is the output bit
    always_comb begin
        sum = {1'b0, acc[WIDTH-1:0]} + {1'b0, active};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pwm_out <= 1'b0;
        end else if (en) begin
            acc     <= sum;
            pwm_out <= sum[WIDTH];
        end else begin
            pwm_out <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= en && (pwm_cnt < active);
        end
    end
`endif

endmodule

// File: rtl/pcm_pwm_dac.sv
// PCM audio sink: valid/ready sample intake, hold register, frame timing and underrun count.
// PCM_PWM_DAC_SIGMA_DELTA_EN selects the sigma-delta modulator in pcm_pwm_mod.
module pcm_pwm_dac
    import pcm_dac_pkg::*;
#(
    parameter int WIDTH              = DEFAULT_WIDTH,
    parameter int PERIODS_PER_SAMPLE = DEFAULT_PERIODS,
    parameter int CNT_WIDTH          = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     pcm_in,
    input  logic                 pcm_vld,
    output logic                 pcm_rdy,
    output logic                 pwm_out,
    output logic                 frame,
    output logic                 underrun,
    output logic [CNT_WIDTH-1:0] underrun_cnt
);

    localparam logic [WIDTH-1:0] MID         = WIDTH'(midscale(WIDTH));
    localparam logic [7:0]       LAST_PERIOD = 8'(PERIODS_PER_SAMPLE - 1);

    logic [WIDTH-1:0] pwm_cnt;
    logic [7:0]       period_cnt;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             live;
    logic             accept;
    logic             boundary;
    load_e            load_sel;

    // live keeps ready low during the first cycle after reset release
    assign pcm_rdy = en && live && !hold_full;

    always_comb begin
        accept   = pcm_vld && pcm_rdy;
        boundary = en && (pwm_cnt == '1) && (period_cnt == LAST_PERIOD);
        load_sel = LOAD_NONE;
        if (boundary) begin
            if (hold_full) begin
                load_sel = LOAD_HOLD;
            end else if (accept) begin
                load_sel = LOAD_BYPASS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            period_cnt   <= '0;
            active       <= MID;
            hold         <= '0;
            hold_full    <= 1'b0;
            live         <= 1'b0;
            frame        <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            live     <= 1'b1;
            frame    <= boundary;
            underrun <= boundary && (load_sel == LOAD_NONE);
            if (en) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_cnt == '1) begin
                    period_cnt <= (period_cnt == LAST_PERIOD) ? '0 : period_cnt + 1'b1;
                end
                if (accept && !boundary) begin
                    hold      <= pcm_in;
                    hold_full <= 1'b1;
                end
                case (load_sel)
                    LOAD_HOLD: begin
                        active    <= hold;
                        hold_full <= 1'b0;
                    end
                    LOAD_BYPASS: begin
                        active <= pcm_in;
                    end
                    default: begin
                        if (boundary && (underrun_cnt != '1)) begin
                            underrun_cnt <= underrun_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    pcm_pwm_mod #(
        .WIDTH (WIDTH)
    ) u_mod (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .active  (active),
`ifndef PCM_PWM_DAC_SIGMA_DELTA_EN
        .pwm_cnt (pwm_cnt),
`endif
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_pcm_pwm_dac.sv
// Self-checking bench for pcm_pwm_dac; a sample queue models the hold register.
// Duty checks allow +-1 when PCM_PWM_DAC_SIGMA_DELTA_EN is defined.
module tb_pcm_pwm_dac;

    localparam int W     = 8;
    localparam int PPS   = 2;
    localparam int CW    = 4;
    localparam int PER   = 1 << W;
    localparam int FRAME = PER * PPS;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [W-1:0]  pcm_in = '0;
    logic          pcm_vld = 1'b0;
    logic          pcm_rdy;
    logic          pwm_out;
    logic          frame;
    logic          underrun;
    logic [CW-1:0] underrun_cnt;

    pcm_pwm_dac #(
        .WIDTH              (W),
        .PERIODS_PER_SAMPLE (PPS),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pcm_in       (pcm_in),
        .pcm_vld      (pcm_vld),
        .pcm_rdy      (pcm_rdy),
        .pwm_out      (pwm_out),
        .frame        (frame),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Accepted samples waiting for the next frame boundary
    logic [W-1:0] sb[$];
    int model_active = 'h80;
    int model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_duty(input string tag, input int ones);
`ifdef PCM_PWM_DAC_SIGMA_DELTA_EN
        checks++;
        assert (ones >= model_active - 1 && ones <= model_active + 1) else begin
            errors++;
            $error("FAIL %s: observed %0d ones expected %0d +-1", tag, ones, model_active);
        end
`else
        check(tag, ones, model_active);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full frame of enabled cycles starting right after a boundary
    task automatic run_frame(input bit send, input logic [W-1:0] data, input int at, input int gap_at);
        int ones;
        int stray;
        bit exp_under;
        ones  = 0;
        stray = 0;
        for (int e = 1; e <= FRAME; e++) begin
            if (send && e == at) begin
                pcm_vld = 1'b1;
                pcm_in  = data;
                check("rdy_at_send", pcm_rdy, sb.size() == 0);
                if (sb.size() == 0) sb.push_back(data);
            end
            step();
            pcm_vld = 1'b0;
            if (e == 1) check("rdy_frame_start", pcm_rdy, sb.size() == 0);
            if (pwm_out === 1'b1) ones++;
            if (e % PER == 0) begin
                check_duty("duty_period", ones);
                ones = 0;
            end
            if (e < FRAME) begin
                if (frame !== 1'b0 || underrun !== 1'b0) stray++;
            end else begin
                check("stray_pulses", stray, 0);
                exp_under = (sb.size() == 0);
                if (!exp_under) model_active = sb.pop_front();
                else if (model_cnt < CMAX) model_cnt++;
                check("frame", frame, 1);
                check("underrun", underrun, exp_under);
                check("underrun_cnt", underrun_cnt, model_cnt);
            end
            if (send && e == at) check("rdy_after_send", pcm_rdy, sb.size() == 0);
            if (e == gap_at) begin
                int gap_ones;
                int gap_pulses;
                gap_ones   = 0;
                gap_pulses = 0;
                en = 1'b0;
                #1;
                check("rdy_en_low", pcm_rdy, 0);
                repeat (50) begin
                    step();
                    if (pwm_out !== 1'b0) gap_ones++;
                    if (frame !== 1'b0 || underrun !== 1'b0) gap_pulses++;
                end
                check("pwm_en_low", gap_ones, 0);
                check("pulses_en_low", gap_pulses, 0);
                en = 1'b1;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rdy"}, pcm_rdy, 0);
        check({tag, "_pwm"}, pwm_out, 0);
        check({tag, "_frame"}, frame, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_cnt"}, underrun_cnt, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, then release away from the clock edge
        repeat (3) step();
        check_reset_state("reset");
        rst_n = 1'b1;
        #1;
        check("rdy_before_first_edge", pcm_rdy, 0);

        // Idle frame: midscale duty, underrun at the first boundary
        run_frame(1'b0, '0, 0, 0);

        // Hold-register load at cycle 10, then 0x00, 0xFF, and a starved frame
        run_frame(1'b1, 8'h40, 10, 0);
        run_frame(1'b1, 8'h00, 10, 0);
        run_frame(1'b1, 8'hFF, 300, 0);
        run_frame(1'b0, '0, 0, 0);

        // Bypass load on the boundary cycle itself
        run_frame(1'b1, 8'hC0, FRAME, 0);

        // Enable gap shifts the boundary by 50 cycles
        run_frame(1'b0, '0, 0, 200);

        // Starve until the underrun counter saturates
        repeat (CMAX + 3) run_frame(1'b0, '0, 0, 0);

        // Mid-frame reset discards the held sample
        repeat (20) step();
        pcm_vld = 1'b1;
        pcm_in  = 8'h10;
        step();
        pcm_vld = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        sb.delete();
        model_active = 'h80;
        model_cnt    = 0;
        step();
        rst_n = 1'b1;
        #1;
        check("rdy_after_midreset", pcm_rdy, 0);
        run_frame(1'b0, '0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
